epochtv1_bgpipe: RTL and testbench

- Background (text/character) fetch-and-serialise stage of the Epoch TV-1 video chip.
- Runs from the shared row/column video counter. Reads tile codes from BGM (background map) and glyph bytes from CHR (character pattern memory).
- Produces one 4-bit background colour plus an opaque flag per pixel clock enable.
- Feeds the render pipeline's priority mux, alongside the sprite OLB read path, with the same 1-cycle output alignment.

---
 rtl/epochtv1_pkg.sv | 24 ++
 rtl/epochtv1_bgpipe.sv | 144 ++++++++++++++
 tb/tb_epochtv1_bgpipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/epochtv1_pkg.sv
// Shared Epoch TV-1 timing constants, background state enum and BGM entry.
// Imported by the background pipe and by the epochtv1 top.
package epochtv1_pkg;

  localparam int FIRST_ROW_RENDER = 21;
  localparam int NUM_ROWS         = 222;
  localparam int LAST_ROW_RENDER  = FIRST_ROW_RENDER + NUM_ROWS - 1;
  localparam int FIRST_COL_RENDER = 28;
  localparam int NUM_COLS         = 192;
  localparam int LAST_COL_RENDER  = FIRST_COL_RENDER + NUM_COLS - 1;
  localparam int TILES_X          = NUM_COLS / 8;

  typedef enum logic [1:0] {
    BST_IDLE,
    BST_FETCH,
    BST_DRAIN
  } bg_state_e;

  typedef struct packed {
    logic       inv;
    logic [6:0] code;
  } bgm_entry_t;

endpackage

// File: rtl/epochtv1_bgpipe.sv
// Epoch TV-1 background fetch/serialise: BGM code -> CHR glyph -> 8px shift.
// Ports: CLK, RST (sync, active-high), CE, ROW/COL counters, BG_EN, FGC/BGC
//   colours; BGM_A/BGM_D and CHR_A/CHR_D 1-CLK memories; BG_PX/BG_OPQ pixel.
module epochtv1_bgpipe
  import epochtv1_pkg::*;
#(
  parameter int FIRST_COL   = FIRST_COL_RENDER,
  parameter int FIRST_ROW   = FIRST_ROW_RENDER,
  parameter int NUM_ROWS_R  = NUM_ROWS,
  parameter int NUM_TILES_X = TILES_X
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [8:0] ROW,
  input  logic [8:0] COL,
  input  logic       BG_EN,
  input  logic [3:0] FGC,
  input  logic [3:0] BGC,
  output logic [8:0] BGM_A,
  input  logic [7:0] BGM_D,
  output logic [9:0] CHR_A,
  input  logic [7:0] CHR_D,
  output logic [3:0] BG_PX,
  output logic       BG_OPQ
);

  localparam logic [8:0] COL_START = 9'(FIRST_COL - 8);
  localparam logic [8:0] COL_WIN0  = 9'(FIRST_COL);
  localparam logic [8:0] COL_WIN1  = 9'(FIRST_COL + 8 * NUM_TILES_X);
  localparam logic [8:0] ROW_0     = 9'(FIRST_ROW);
  localparam logic [8:0] ROW_END   = 9'(FIRST_ROW + NUM_ROWS_R);
  localparam logic [4:0] LAST_TILE = 5'(NUM_TILES_X - 1);

  bg_state_e  state_q;
  logic [2:0] phase_q;
  logic [4:0] tcol_q;
  bgm_entry_t ent_q;
  logic [7:0] hold_q;
  logic [7:0] shf_q, shf_d;
  logic [7:0] vld_q, vld_d;
  logic [8:0] bgm_a_q;
  logic [9:0] chr_a_q;
  logic [3:0] px_q;
  logic       opq_q;
  logic       bgoff_q;

  logic [8:0] rr;
  logic [3:0] trow;
  logic [2:0] line;
  logic       render_row;
  logic       in_win;
  logic       unused_rr;

  assign rr         = ROW - ROW_0;
  assign trow       = rr[7:4];
  assign line       = rr[3:1];
  assign unused_rr  = rr[8] ^ rr[0];
  assign render_row = (ROW >= ROW_0) && (ROW < ROW_END);
  assign in_win     = (COL >= COL_WIN0) && (COL < COL_WIN1);

  // Slot 7 reload wins over the per-pixel shift.
  always_comb begin
    shf_d = {shf_q[6:0], 1'b0};
    vld_d = {vld_q[6:0], 1'b0};
    if (state_q == BST_FETCH && phase_q == 3'd7) begin
      shf_d = hold_q;
      vld_d = 8'hFF;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BST_IDLE;
      phase_q <= '0;
      tcol_q  <= '0;
      ent_q   <= '0;
      hold_q  <= '0;
      shf_q   <= '0;
      vld_q   <= '0;
      bgm_a_q <= '0;
      chr_a_q <= '0;
      px_q    <= '0;
      opq_q   <= 1'b0;
      bgoff_q <= 1'b0;
    end else if (CE) begin
      // Lines with BG disabled at start show flat BGC over the window.
      if (COL == COL_START) bgoff_q <= render_row && !BG_EN;

      if (vld_q[7]) begin
        opq_q <= shf_q[7];
        px_q  <= shf_q[7] ? FGC : BGC;
      end else if (bgoff_q && in_win) begin
        opq_q <= 1'b0;
        px_q  <= BGC;
      end else begin
        opq_q <= 1'b0;
        px_q  <= '0;
      end

      unique case (state_q)
        BST_IDLE: begin
          // The start CE is itself slot 0, so the map address goes out now.
          if (render_row && BG_EN && COL == COL_START) begin
            state_q <= BST_FETCH;
            phase_q <= 3'd1;
            tcol_q  <= '0;
            bgm_a_q <= {trow, 5'd0};
          end
        end
        BST_FETCH: begin
          phase_q <= phase_q + 3'd1;
          shf_q   <= shf_d;
          vld_q   <= vld_d;
          unique case (phase_q)
            3'd0: bgm_a_q <= {trow, tcol_q};
            3'd2: begin
              ent_q   <= bgm_entry_t'(BGM_D);
              chr_a_q <= {BGM_D[6:0], line};
            end
            3'd4: hold_q <= CHR_D ^ {8{ent_q.inv}};
            3'd7: begin
              tcol_q <= tcol_q + 5'd1;
              if (tcol_q == LAST_TILE) state_q <= BST_DRAIN;
            end
            default: ;
          endcase
        end
        BST_DRAIN: begin
          shf_q <= shf_d;
          vld_q <= vld_d;
          if (vld_d == 8'h00) state_q <= BST_IDLE;
        end
        default: state_q <= BST_IDLE;
      endcase
    end
  end

  assign BGM_A  = bgm_a_q;
  assign CHR_A  = chr_a_q;
  assign BG_PX  = px_q;
  assign BG_OPQ = opq_q;

endmodule

// File: tb/tb_epochtv1_bgpipe.sv
// Directed + randomized bench for epochtv1_bgpipe against a pixel-level
// model of map/glyph lookup and the fetch address schedule.
module tb_epochtv1_bgpipe;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CE = 1'b0;
  logic [8:0] ROW = '0;
  logic [8:0] COL = '0;
  logic       BG_EN = 1'b0;
  logic [3:0] FGC = '0;
  logic [3:0] BGC = '0;
  logic [8:0] BGM_A;
  logic [7:0] BGM_D;
  logic [9:0] CHR_A;
  logic [7:0] CHR_D;
  logic [3:0] BG_PX;
  logic       BG_OPQ;

  logic [7:0] bgm [512];
  logic [7:0] chr [1024];

  int vecs = 0;
  int errs = 0;

  logic [8:0] exp_a = '0;
  logic [9:0] exp_c = '0;

  epochtv1_bgpipe dut (
    .CLK(CLK), .RST(RST), .CE(CE), .ROW(ROW), .COL(COL),
    .BG_EN(BG_EN), .FGC(FGC), .BGC(BGC),
    .BGM_A(BGM_A), .BGM_D(BGM_D), .CHR_A(CHR_A), .CHR_D(CHR_D),
    .BG_PX(BG_PX), .BG_OPQ(BG_OPQ)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    BGM_D <= bgm[BGM_A];
    CHR_D <= chr[CHR_A];
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {opq, colour} shown during the cycle after the CE at column c.
  function automatic logic [4:0] ref_px(int row, int c, bit ben,
                                        logic [3:0] fg, logic [3:0] bg);
    int x;
    int rr;
    logic [7:0] e;
    logic [7:0] g;
    logic o;
    x  = c - 28;
    rr = row - 21;
    if (row < 21 || row >= 243 || x < 0 || x >= 192) return 5'd0;
    if (!ben) return {1'b0, bg};
    e = bgm[((rr / 16) % 16) * 32 + x / 8];
    g = chr[(e & 127) * 8 + (rr / 2) % 8];
    if (e[7]) g = ~g;
    o = g[7 - x % 8];
    return {o, o ? fg : bg};
  endfunction

  task automatic check_all(input string tag, input logic [4:0] cur);
    chk({tag, "_px"}, 16'({BG_OPQ, BG_PX}), 16'(cur));
    chk({tag, "_bgma"}, 16'(BGM_A), 16'(exp_a));
    chk({tag, "_chra"}, 16'(CHR_A), 16'(exp_c));
  endtask

  task automatic run_line(input string tag, input int row, input bit ben0,
                          input bit ben_flip, input bit rnd_col,
                          input bit ce_gaps, input int rst_col);
    bit ben_line;
    bit dead;
    bit fetch;
    logic [4:0] cur;
    int rr;
    int trow;
    int t;
    ben_line = 1'b0;
    dead = 1'b0;
    cur = 5'd0;
    rr = row - 21;
    trow = (rr / 16) % 16;
    for (int c = 0; c < 256; c++) begin
      if (ce_gaps) begin
        repeat ($urandom_range(0, 2)) begin
          CE = 1'b0;
          RST = 1'b0;
          @(posedge CLK); #1;
          check_all({tag, "_gap"}, cur);
        end
      end
      ROW = 9'(row);
      COL = 9'(c);
      CE = 1'b1;
      BG_EN = (ben_flip && c >= 50) ? ~ben0 : ben0;
      if (rnd_col) begin
        FGC = 4'($urandom);
        BGC = 4'($urandom);
      end
      RST = (c == rst_col);
      if (c == 20) ben_line = BG_EN;
      if (c == rst_col) dead = 1'b1;
      fetch = (row >= 21) && (row < 243) && ben_line && !dead;
      @(posedge CLK); #1;
      if (dead) begin
        cur = 5'd0;
        exp_a = '0;
        exp_c = '0;
      end else begin
        cur = ref_px(row, c, ben_line, FGC, BGC);
      end
      if (fetch && c >= 20 && c <= 204 && (c - 20) % 8 == 0)
        exp_a = 9'(trow * 32 + (c - 20) / 8);
      if (fetch && c >= 22 && c <= 206 && (c - 22) % 8 == 0) begin
        t = (c - 22) / 8;
        exp_c = 10'((bgm[trow * 32 + t] & 127) * 8 + (rr / 2) % 8);
      end
      check_all(tag, cur);
    end
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) bgm[i] = 8'h00;
    for (int i = 0; i < 1024; i++) chr[i] = 8'h00;

    // Reset with CE low: reset must not depend on CE.
    RST = 1'b1;
    CE = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_px", 16'(BG_PX), 16'h0);
    chk("rst_opq", 16'(BG_OPQ), 16'h0);
    chk("rst_bgma", 16'(BGM_A), 16'h0);
    chk("rst_chra", 16'(CHR_A), 16'h0);
    RST = 1'b0;

    // Single tile with a leftmost-pixel glyph.
    bgm[0] = 8'h01;
    for (int i = 8; i < 16; i++) chr[i] = 8'h80;
    FGC = 4'hF;
    BGC = 4'h2;
    run_line("tile1", 21, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Inverted tile.
    bgm[0] = 8'h81;
    run_line("inv", 21, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Random map/glyphs; address math on a wrapped high row.
    for (int i = 0; i < 512; i++) bgm[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) chr[i] = 8'($urandom);
    run_line("row234", 234, 1'b1, 1'b0, 1'b1, 1'b0, -1);

    // BG disabled at line start, then enabled mid-line: no fetch.
    FGC = 4'hA;
    BGC = 4'h5;
    run_line("bgoff", 21, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    // Non-render rows above and below the window.
    run_line("norend", 10, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    run_line("last", 242, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    run_line("past", 243, 1'b1, 1'b0, 1'b1, 1'b0, -1);

    // Sparse CE, colours changing per pixel, BG_EN dropped mid-line.
    run_line("cegap", 100, 1'b1, 1'b1, 1'b1, 1'b1, -1);

    // Reset mid-line, then a clean following line.
    run_line("rstmid", 40, 1'b1, 1'b0, 1'b1, 1'b0, 100);
    run_line("after", 41, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    run_line("rnd", 57, 1'b1, 1'b0, 1'b1, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
